jtframe_sdram_resp: RTL and testbench



---
 rtl/jtframe_sdram_resp.sv | 132 +++++++++++++
 tb/tb_jtframe_sdram_resp.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_sdram_resp.sv
// SDRAM-like responder backed by on-chip block RAM: burst reads, masked
// download writes, and periodic refresh stalls with SDRAM-style latencies.
module jtframe_sdram_resp #(
    parameter int AW         = 12,
    parameter int RCD        = 2,
    parameter int CL         = 2,
    parameter int REF_PERIOD = 390,
    parameter int REF_LEN    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_req,
    input  logic [21:0] sdram_addr,
    input  logic        downloading,
    input  logic        prog_we,
    input  logic [21:0] prog_addr,
    input  logic [15:0] prog_data,
    input  logic [1:0]  prog_mask,
    output logic        sdram_ack,
    output logic        data_dst,
    output logic        data_rdy,
    output logic [15:0] data_read,
    output logic        busy
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ACT  = 3'd1;
    localparam logic [2:0] ACK  = 3'd2;
    localparam logic [2:0] CAS  = 3'd3;
    localparam logic [2:0] DST  = 3'd4;
    localparam logic [2:0] RDY  = 3'd5;
    localparam logic [2:0] WR   = 3'd6;
    localparam logic [2:0] REF  = 3'd7;

    localparam int WMAX0 = (RCD > CL) ? RCD : CL;
    localparam int WMAX  = (WMAX0 > REF_LEN) ? WMAX0 : REF_LEN;
    localparam int WCW   = $clog2(WMAX + 1);
    localparam int RCW   = $clog2(REF_PERIOD);

    logic [2:0]     state, state_nx, dispatch;
    logic [WCW-1:0] cnt;
    logic [RCW-1:0] ref_cnt;
    logic           ref_pend, ref_wrap, enter, wr_en;
    logic [AW-1:0]  a_reg;
    logic [15:0]    mem [2**AW];
    logic           unused_addr;

    assign unused_addr = ^{sdram_addr[21:AW], prog_addr[21:AW]};

    always_comb begin
        dispatch = IDLE;
        if (ref_pend)
            dispatch = REF;
        else if (downloading && prog_we)
            dispatch = WR;
        else if (sdram_req && !downloading)
            dispatch = ACT;
    end

    // The last refresh cycle dispatches directly so a waiting request is
    // delayed by exactly REF_LEN cycles instead of REF_LEN+1.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = dispatch;
            ACT:     if (cnt == '0) state_nx = ACK;
            ACK:     state_nx = CAS;
            CAS:     if (cnt == '0) state_nx = DST;
            DST:     state_nx = RDY;
            RDY:     state_nx = IDLE;
            WR:      state_nx = IDLE;
            REF:     if (cnt == '0) state_nx = dispatch;
            default: state_nx = IDLE;
        endcase
    end

    assign enter    = (state_nx != state) || (state == REF && cnt == '0);
    assign ref_wrap = (ref_cnt == RCW'(REF_PERIOD - 1));
    assign wr_en    = rst_n && (state_nx == WR);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (!prog_mask[1]) mem[prog_addr[AW-1:0]][15:8] <= prog_data[15:8];
            if (!prog_mask[0]) mem[prog_addr[AW-1:0]][7:0]  <= prog_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ref_cnt   <= '0;
            ref_pend  <= 1'b0;
            a_reg     <= '0;
            sdram_ack <= 1'b0;
            data_dst  <= 1'b0;
            data_rdy  <= 1'b0;
            data_read <= '0;
            busy      <= 1'b0;
        end else begin
            state   <= state_nx;
            ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
            // A new wrap wins over the clear so it is never lost.
            if (ref_wrap)
                ref_pend <= 1'b1;
            else if (enter && state_nx == REF)
                ref_pend <= 1'b0;

            if (enter) begin
                case (state_nx)
                    ACT:     cnt <= WCW'(RCD - 1);
                    CAS:     cnt <= WCW'(CL - 1);
                    REF:     cnt <= WCW'(REF_LEN - 1);
                    default: cnt <= '0;
                endcase
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (enter && state_nx == ACT)
                a_reg <= sdram_addr[AW-1:0];

            sdram_ack <= (state_nx == ACK) || (state_nx == WR);
            data_dst  <= (state_nx == DST);
            data_rdy  <= (state_nx == RDY);
            busy      <= (state_nx != IDLE);
            if (state_nx == DST)
                data_read <= mem[a_reg];
            else if (state_nx == RDY)
                data_read <= mem[a_reg + AW'(1)];
        end
    end
endmodule

// File: tb/tb_jtframe_sdram_resp.sv
// Directed bench for jtframe_sdram_resp: default-parameter instance plus a
// short-refresh instance for the refresh collision case.
module tb_jtframe_sdram_resp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sdram_req, downloading, prog_we;
    logic [21:0] sdram_addr, prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic        sdram_ack, data_dst, data_rdy, busy;
    logic [15:0] data_read;

    logic        sdram_req_r, downloading_r, prog_we_r;
    logic [21:0] sdram_addr_r, prog_addr_r;
    logic [15:0] prog_data_r;
    logic [1:0]  prog_mask_r;
    logic        sdram_ack_r, data_dst_r, data_rdy_r, busy_r;
    logic [15:0] data_read_r;

    jtframe_sdram_resp dut (
        .clk(clk), .rst_n(rst_n), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .downloading(downloading), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_mask(prog_mask), .sdram_ack(sdram_ack),
        .data_dst(data_dst), .data_rdy(data_rdy), .data_read(data_read), .busy(busy)
    );

    jtframe_sdram_resp #(.REF_PERIOD(16), .REF_LEN(4)) dut_r (
        .clk(clk), .rst_n(rst_n), .sdram_req(sdram_req_r), .sdram_addr(sdram_addr_r),
        .downloading(downloading_r), .prog_we(prog_we_r), .prog_addr(prog_addr_r),
        .prog_data(prog_data_r), .prog_mask(prog_mask_r), .sdram_ack(sdram_ack_r),
        .data_dst(data_dst_r), .data_rdy(data_rdy_r), .data_read(data_read_r), .busy(busy_r)
    );

    // Refresh phase: value of each instance's refresh counter during the current cycle.
    int ph, ph_r;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph   <= 0;
            ph_r <= 0;
        end else begin
            ph   <= (ph == 389) ? 0 : ph + 1;
            ph_r <= (ph_r == 15) ? 0 : ph_r + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Keep timed tests on the default instance clear of its refresh window.
    task automatic ref_guard();
        for (int k = 0; k < 500 && (ph >= 360 || ph < 20); k++) @(negedge clk);
    endtask

    task automatic read_burst(input string tag, input logic [21:0] a,
                              input logic [15:0] e0, input logic [15:0] e1, input int ack_exp);
        int ack_o, dst_o, rdy_o;
        logic [15:0] d0, d1;
        ack_o = -1; dst_o = -1; rdy_o = -1; d0 = '0; d1 = '0;
        sdram_req  = 1'b1;
        sdram_addr = a;
        for (int k = 1; k <= 30 && rdy_o < 0; k++) begin
            @(negedge clk);
            if (sdram_ack && ack_o < 0) begin ack_o = k; sdram_req = 1'b0; end
            if (data_dst && dst_o < 0)  begin dst_o = k; d0 = data_read; end
            if (data_rdy && rdy_o < 0)  begin rdy_o = k; d1 = data_read; end
        end
        sdram_req = 1'b0;
        @(negedge clk);
        check({tag, "_ack_cyc"}, ack_o, ack_exp);
        check({tag, "_dst_cyc"}, dst_o, ack_exp + 3);
        check({tag, "_rdy_cyc"}, rdy_o, ack_exp + 4);
        check({tag, "_word0"}, d0, e0);
        check({tag, "_word1"}, d1, e1);
    endtask

    task automatic do_write(input bit sel, input logic [21:0] a, input logic [15:0] d,
                            input logic [1:0] m, output int off);
        off = -1;
        if (sel) begin
            prog_we_r = 1'b1; prog_addr_r = a; prog_data_r = d; prog_mask_r = m;
        end else begin
            prog_we = 1'b1; prog_addr = a; prog_data = d; prog_mask = m;
        end
        for (int k = 1; k <= 40 && off < 0; k++) begin
            @(negedge clk);
            if (sel ? sdram_ack_r : sdram_ack) off = k;
        end
        prog_we   = 1'b0;
        prog_we_r = 1'b0;
        @(negedge clk);
    endtask

    logic [21:0] pre_a [8];
    logic [15:0] pre_d [8];
    logic [21:0] b2b_a [3];
    logic [15:0] b2b_e0 [3];
    logic [15:0] b2b_e1 [3];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int off, seen, na, nd, nr, bsy;
        int ack_t [3];
        logic [15:0] dd0 [3];
        logic [15:0] dd1 [3];
        int ack_o, dst_o, rdy_o;
        logic [15:0] c0, c1;

        pre_a = '{22'h010, 22'h011, 22'hFFF, 22'h000, 22'h030, 22'h031, 22'h040, 22'h041};
        pre_d = '{16'h1234, 16'hABCD, 16'h7777, 16'h0F0F, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
        b2b_a  = '{22'h030, 22'h040, 22'h010};
        b2b_e0 = '{16'h1111, 16'h3333, 16'h1234};
        b2b_e1 = '{16'h2222, 16'h4444, 16'hABCD};

        rst_n = 1'b0;
        sdram_req = 0; sdram_addr = '0; downloading = 0; prog_we = 0;
        prog_addr = '0; prog_data = '0; prog_mask = '0;
        sdram_req_r = 0; sdram_addr_r = '0; downloading_r = 0; prog_we_r = 0;
        prog_addr_r = '0; prog_data_r = '0; prog_mask_r = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {sdram_ack, data_dst, data_rdy, busy, data_read}, '0);
        check("reset_outputs_r", {sdram_ack_r, data_dst_r, data_rdy_r, busy_r, data_read_r}, '0);
        rst_n = 1'b1;

        downloading = 1'b1;
        for (int i = 0; i < 8; i++) begin
            do_write(1'b0, pre_a[i], pre_d[i], 2'b00, off);
            check("preload_ack", off > 0, 1);
        end
        downloading = 1'b0;
        downloading_r = 1'b1;
        for (int i = 0; i < 2; i++) begin
            do_write(1'b1, pre_a[i], pre_d[i], 2'b00, off);
            check("preload_r_ack", off > 0, 1);
        end
        downloading_r = 1'b0;

        ref_guard();
        read_burst("rd_basic", 22'h010, 16'h1234, 16'hABCD, 3);
        ref_guard();
        read_burst("rd_wrap", 22'hFFF, 16'h7777, 16'h0F0F, 3);
        ref_guard();
        read_burst("rd_upper", 22'h3FF010, 16'h1234, 16'hABCD, 3);

        downloading = 1'b1;
        ref_guard();
        do_write(1'b0, 22'h020, 16'h5AA5, 2'b00, off);
        check("wr_full_ack_cyc", off, 1);
        do_write(1'b0, 22'h020, 16'hFF00, 2'b10, off);
        check("wr_lo_ack_cyc", off, 1);
        do_write(1'b0, 22'h021, 16'h6006, 2'b00, off);
        check("wr_21_ack_cyc", off, 1);
        do_write(1'b0, 22'h021, 16'hBEEF, 2'b11, off);
        check("wr_mask11_ack_cyc", off, 1);
        seen = 0;
        sdram_req = 1'b1; sdram_addr = 22'h010;
        repeat (12) begin
            @(negedge clk);
            if (sdram_ack) seen = 1;
        end
        sdram_req = 1'b0;
        @(negedge clk);
        check("dl_read_noack", seen, 0);
        downloading = 1'b0;
        @(negedge clk);
        ref_guard();
        read_burst("rd_dl", 22'h020, 16'h5A00, 16'h6006, 3);

        ref_guard();
        na = 0; nd = 0; nr = 0;
        sdram_req = 1'b1; sdram_addr = b2b_a[0];
        for (int k = 1; k <= 40 && nr < 3; k++) begin
            @(negedge clk);
            if (sdram_ack && na < 3) begin
                ack_t[na] = k;
                na++;
                if (na < 3) sdram_addr = b2b_a[na];
                else sdram_req = 1'b0;
            end
            if (data_dst && nd < 3) begin dd0[nd] = data_read; nd++; end
            if (data_rdy && nr < 3) begin dd1[nr] = data_read; nr++; end
        end
        sdram_req = 1'b0;
        check("b2b_ack_count", na, 3);
        check("b2b_first_ack", ack_t[0], 3);
        check("b2b_ack_gap1", ack_t[1] - ack_t[0], 8);
        check("b2b_ack_gap2", ack_t[2] - ack_t[1], 8);
        for (int i = 0; i < 3; i++) begin
            check("b2b_word0", dd0[i], b2b_e0[i]);
            check("b2b_word1", dd1[i], b2b_e1[i]);
        end
        repeat (2) @(negedge clk);

        ref_guard();
        seen = 0;
        sdram_req = 1'b1; sdram_addr = 22'h010;
        for (int k = 1; k <= 20 && seen == 0; k++) begin
            @(negedge clk);
            if (sdram_ack) seen = 1;
        end
        sdram_req = 1'b0;
        check("rst_pre_ack", seen, 1);
        @(negedge clk);
        check("rst_in_cas", {busy, data_dst, data_rdy, data_read}, {3'b100, 16'hABCD});
        rst_n = 1'b0;
        #1;
        check("rst_async_zero", {sdram_ack, data_dst, data_rdy, busy, data_read}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        read_burst("rd_post_rst", 22'h010, 16'h1234, 16'hABCD, 3);

        // Request the short-refresh instance in the cycle its refresh becomes pending.
        for (int k = 0; k < 40 && ph_r != 0; k++) @(negedge clk);
        check("coll_phase", ph_r, 0);
        ack_o = -1; dst_o = -1; rdy_o = -1; c0 = '0; c1 = '0; bsy = 0;
        sdram_req_r = 1'b1; sdram_addr_r = 22'h010;
        for (int k = 1; k <= 30 && rdy_o < 0; k++) begin
            @(negedge clk);
            if (k <= 4 && busy_r) bsy++;
            if (sdram_ack_r && ack_o < 0) begin ack_o = k; sdram_req_r = 1'b0; end
            if (data_dst_r && dst_o < 0)  begin dst_o = k; c0 = data_read_r; end
            if (data_rdy_r && rdy_o < 0)  begin rdy_o = k; c1 = data_read_r; end
        end
        sdram_req_r = 1'b0;
        check("coll_ref_busy", bsy, 4);
        check("coll_ack_cyc", ack_o, 7);
        check("coll_dst_cyc", dst_o, 10);
        check("coll_rdy_cyc", rdy_o, 11);
        check("coll_word0", c0, 16'h1234);
        check("coll_word1", c1, 16'hABCD);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
